// File: rtl/hdlc_rx_framequeue.sv
// HDLC receive frame queue.
// Buffers up to NFRAMES complete frames of up to DEPTH bytes each between the Rx channel and
// the host. Frames with FCS errors, aborts, lost bytes or an empty payload are discarded. The
// host reads the oldest frame byte by byte, or drops it early.
module hdlc_rx_framequeue #(
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned NFRAMES = 2,
  parameter int unsigned SIZE_W  = $clog2(DEPTH + 1)
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic [7:0]                     Rx_Data,
  input  logic                           Rx_WrBuff,
  input  logic                           Rx_EoF,
  input  logic                           Rx_FCSerr,
  input  logic                           Rx_FCSen,
  input  logic                           Rx_AbortSignal,
  input  logic                           Rx_RdBuff,
  input  logic                           Rx_Drop,
  output logic [7:0]                     Rx_DataBuffOut,
  output logic                           Rx_Ready,
  output logic [SIZE_W-1:0]              Rx_FrameSize,
  output logic                           Rx_Overflow,
  output logic                           Rx_FrameError,
  output logic [$clog2(NFRAMES+1)-1:0]   Rx_FramesPending
);

  localparam int unsigned SlotW = (NFRAMES > 1) ? $clog2(NFRAMES) : 1;
  localparam int unsigned IdxW  = $clog2(DEPTH);
  localparam int unsigned PendW = $clog2(NFRAMES + 1);

  localparam logic [SlotW-1:0]  LastSlot   = SlotW'(NFRAMES - 1);
  localparam logic [SIZE_W-1:0] DepthSz    = SIZE_W'(DEPTH);
  localparam logic [PendW-1:0]  NFramesCnt = PendW'(NFRAMES);

  // Slot storage and per-slot metadata
  logic [7:0]         mem_q  [NFRAMES][DEPTH];
  logic [SIZE_W-1:0]  size_q [NFRAMES];
  logic [SIZE_W-1:0]  size_d [NFRAMES];
  logic [NFRAMES-1:0] ovf_q, ovf_d;

  // Write side state
  logic [SlotW-1:0]  wr_slot_q, wr_slot_d;
  logic [SIZE_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic              lost_pend_q, lost_pend_d;
  logic              frame_err_q, frame_err_d;

  // Read side state
  logic [SlotW-1:0]  rd_slot_q, rd_slot_d;
  logic [SIZE_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [7:0]        dout_q, dout_d;

  // Committed frame count
  logic [PendW-1:0]  cnt_q, cnt_d;

  logic              mem_we;
  logic              commit;
  logic              release_head;
  logic              ready;
  logic [SIZE_W-1:0] len;

  function automatic logic [SlotW-1:0] next_slot(input logic [SlotW-1:0] s);
    return (s == LastSlot) ? '0 : s + SlotW'(1);
  endfunction

  assign ready = (cnt_q != '0);

  // Write path: byte capture, overflow/loss tracking and commit at end of frame
  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    wr_slot_d   = wr_slot_q;
    ovf_pend_d  = ovf_pend_q;
    lost_pend_d = lost_pend_q;
    size_d      = size_q;
    ovf_d       = ovf_q;
    frame_err_d = 1'b0;
    mem_we      = 1'b0;
    commit      = 1'b0;
    len         = '0;
    if (Rx_AbortSignal) begin
      wr_cnt_d    = '0;
      ovf_pend_d  = 1'b0;
      lost_pend_d = 1'b0;
    end else begin
      if (Rx_WrBuff) begin
        if (cnt_q == NFramesCnt) begin
          lost_pend_d = 1'b1;
        end else if (wr_cnt_q < DepthSz) begin
          mem_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + SIZE_W'(1);
        end else begin
          ovf_pend_d = 1'b1;
        end
      end
      if (Rx_EoF) begin
        // Commit sees the byte written in this same cycle
        if (Rx_FCSen) begin
          len = (wr_cnt_d >= SIZE_W'(2)) ? wr_cnt_d - SIZE_W'(2) : '0;
        end else begin
          len = wr_cnt_d;
        end
        if (Rx_FCSerr || lost_pend_d || (len == '0)) begin
          frame_err_d = 1'b1;
        end else begin
          commit            = 1'b1;
          size_d[wr_slot_q] = len;
          ovf_d[wr_slot_q]  = ovf_pend_d;
          wr_slot_d         = next_slot(wr_slot_q);
        end
        wr_cnt_d    = '0;
        ovf_pend_d  = 1'b0;
        lost_pend_d = 1'b0;
      end
    end
  end

  // Read path: byte fetch from the head slot and head release on last byte or drop
  always_comb begin
    rd_cnt_d     = rd_cnt_q;
    rd_slot_d    = rd_slot_q;
    dout_d       = dout_q;
    release_head = 1'b0;
    if (Rx_Drop && ready) begin
      release_head = 1'b1;
    end else if (Rx_RdBuff && ready) begin
      dout_d = mem_q[rd_slot_q][rd_cnt_q[IdxW-1:0]];
      if (rd_cnt_q == size_q[rd_slot_q] - SIZE_W'(1)) begin
        release_head = 1'b1;
      end else begin
        rd_cnt_d = rd_cnt_q + SIZE_W'(1);
      end
    end
    if (release_head) begin
      rd_cnt_d  = '0;
      rd_slot_d = next_slot(rd_slot_q);
    end
  end

  // Committed count: simultaneous commit and release cancel out
  always_comb begin
    cnt_d = cnt_q;
    unique case ({commit, release_head})
      2'b10:   cnt_d = cnt_q + PendW'(1);
      2'b01:   cnt_d = cnt_q - PendW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Byte storage; contents are never cleared, only the pointers are
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[wr_slot_q][wr_cnt_q[IdxW-1:0]] <= Rx_Data;
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_slot_q   <= '0;
      wr_cnt_q    <= '0;
      ovf_pend_q  <= 1'b0;
      lost_pend_q <= 1'b0;
      frame_err_q <= 1'b0;
      rd_slot_q   <= '0;
      rd_cnt_q    <= '0;
      dout_q      <= '0;
      cnt_q       <= '0;
      ovf_q       <= '0;
      for (int i = 0; i < NFRAMES; i++) begin
        size_q[i] <= '0;
      end
    end else begin
      wr_slot_q   <= wr_slot_d;
      wr_cnt_q    <= wr_cnt_d;
      ovf_pend_q  <= ovf_pend_d;
      lost_pend_q <= lost_pend_d;
      frame_err_q <= frame_err_d;
      rd_slot_q   <= rd_slot_d;
      rd_cnt_q    <= rd_cnt_d;
      dout_q      <= dout_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      size_q      <= size_d;
    end
  end

  assign Rx_DataBuffOut   = dout_q;
  assign Rx_Ready         = ready;
  assign Rx_FrameSize     = ready ? size_q[rd_slot_q] : '0;
  assign Rx_Overflow      = ready ? ovf_q[rd_slot_q] : 1'b0;
  assign Rx_FrameError    = frame_err_q;
  assign Rx_FramesPending = cnt_q;

endmodule

// File: doc/hdlc_rx_framequeue.md
# hdlc_rx_framequeue

Parametrised receive frame queue for the HDLC controller, sitting between the Rx channel (byte strobes, end-of-frame, FCS status) and the host register interface. It stores up to NFRAMES complete frames of up to DEPTH bytes each and strips the FCS bytes from the reported length. Frames with FCS errors or aborts are discarded, and the queue tracks overflow per frame. The host reads the oldest frame byte by byte and may drop it early.

## Interface
- DEPTH, 128: byte capacity of one frame slot (≥ 4)
- NFRAMES, 2: number of frame slots (≥ 1)
- SIZE_W, $clog2(DEPTH+1): width of frame-size fields
- Clk  in  1  clock; all logic on rising edge
- Rst  in  1  synchronous, active-high reset
- Rx_Data  in  8  received byte
- Rx_WrBuff  in  1  write strobe for Rx_Data
- Rx_EoF  in  1  end-of-frame pulse, after the last Rx_WrBuff
- Rx_FCSerr  in  1  FCS status, sampled with Rx_EoF
- Rx_FCSen  in  1  when 1, the last 2 written bytes are FCS; sampled with Rx_EoF
- Rx_AbortSignal  in  1  abort current in-progress frame
- Rx_RdBuff  in  1  host read strobe
- Rx_Drop  in  1  host discards head frame
- Rx_DataBuffOut  out  8  read data, registered
- Rx_Ready  out  1  at least one committed frame queued
- Rx_FrameSize  out  SIZE_W  payload length of head frame, 0 when not ready
- Rx_Overflow  out  1  head frame exceeded DEPTH (truncated)
- Rx_FrameError  out  1  one-cycle pulse: in-progress frame discarded at EoF
- Rx_FramesPending  out  $clog2(NFRAMES+1)  committed frame count

## Operation
- Storage: NFRAMES×DEPTH byte array as ring of slots. Per-slot metadata: size and overflow flag. Write slot index wr_slot, write count wr_cnt, head index rd_slot, read count rd_cnt, committed count cnt.
- Write path, slot free (cnt < NFRAMES):
  - On Rx_WrBuff with wr_cnt < DEPTH: store byte at [wr_slot][wr_cnt] and increment wr_cnt.
  - On Rx_WrBuff with wr_cnt == DEPTH: drop the byte and set ovf_pend.
- Write path, no free slot (cnt == NFRAMES): bytes are not stored; set lost_pend.
- Commit on Rx_EoF:
  - Compute len = wr_cnt − (Rx_FCSen ? 2 : 0), saturating at 0.
  - Discard if Rx_FCSerr, lost_pend, or len == 0. Discard pulses Rx_FrameError.
  - Otherwise write size = len and ovf = ovf_pend into the slot metadata, increment wr_slot mod NFRAMES, and increment cnt.
  - Either way, clear wr_cnt, ovf_pend and lost_pend.
- Abort: Rx_AbortSignal clears wr_cnt, ovf_pend and lost_pend with no commit and no FrameError. Abort has priority over Rx_EoF and Rx_WrBuff in the same cycle.
- Rx_WrBuff and Rx_EoF in the same cycle: the byte is counted first, then the commit uses the updated wr_cnt.
- Read path:
  - Rx_RdBuff with Rx_Ready: Rx_DataBuffOut <= [rd_slot][rd_cnt], then rd_cnt++.
  - If that read was byte size−1: release the head, i.e. rd_slot++ mod NFRAMES, rd_cnt = 0, cnt−−.
  - Rx_RdBuff without Rx_Ready is ignored; Rx_DataBuffOut holds its value.
- Rx_Drop with Rx_Ready: release the head immediately (rd_cnt = 0, no data update). Drop wins over Rx_RdBuff in the same cycle. Drop with no frame queued is ignored.
- Commit and release in the same cycle: cnt unchanged, and both pointers advance.
- Status outputs are combinational from registered state:
  - Rx_Ready = (cnt ≠ 0).
  - Rx_FrameSize = head size when Rx_Ready, else 0.
  - Rx_Overflow = head ovf when Rx_Ready, else 0.
  - Rx_FramesPending = cnt.

## Timing
- Reset values: Rx_DataBuffOut 0, Rx_Ready 0, Rx_FrameSize 0, Rx_Overflow 0, Rx_FrameError 0, Rx_FramesPending 0. All pointers, counts and pending flags are cleared.
- Reset mid-frame or mid-read discards everything; stored bytes need no clearing.
- Commit (EoF at cycle n): Rx_Ready, Rx_FrameSize and Rx_FramesPending update at cycle n+1.
- Read latency: Rx_RdBuff at cycle n gives Rx_DataBuffOut valid at n+1. Back-to-back reads are allowed, one byte per cycle.
- Final byte read at cycle n: the byte appears at n+1. In the same cycle n+1 the status outputs already show the next head, or Ready = 0.
- Rx_FrameError: single-cycle pulse at n+1 after the discarding Rx_EoF.
- Write path and read path operate concurrently every cycle.

## Test plan
- Frame of 6 bytes 0x01..0x06, FCSen=1, FCSerr=0 -> next cycle Ready=1, FrameSize=4, Overflow=0. Four reads return 0x01..0x04, then Ready=0 and FramesPending=0.
- DEPTH=128, 130 bytes written, FCSen=0 -> FrameSize=128, Overflow=1. The 128th read returns byte 128; bytes 129–130 are never output.
- NFRAMES=2: three frames committed without reads -> FramesPending=2; third EoF pulses FrameError. Read both -> original two frames returned intact.
- Frame with FCSerr=1 at EoF -> FrameError pulse, Ready stays 0. Abort after 3 bytes, then a 2-byte frame with FCSen=0 -> FrameSize=2 and data correct.
- Two frames queued: Rx_Drop and Rx_RdBuff asserted together -> head released, Rx_DataBuffOut unchanged, FrameSize shows the second frame.
- Rst asserted mid-frame and mid-read -> all outputs 0 next cycle; a new 1-byte frame (FCSen=0) afterwards reads back correctly.
